// File: rtl/rr_decode_arbiter_if.sv
// Request/grant bundle between requesters and the round-robin decode arbiter.
// The arbiter uses the slave modport; the requester side (or a bench) uses master.
interface rr_decode_arbiter_if;
  logic [7:0] i_req;
  logic       i_release;
  logic [7:0] o_gnt;
  logic [2:0] o_gnt_idx;
  logic       o_gnt_valid;
  logic       o_timeout;

  modport master (
    output i_req,
    output i_release,
    input  o_gnt,
    input  o_gnt_idx,
    input  o_gnt_valid,
    input  o_timeout
  );

  modport slave (
    input  i_req,
    input  i_release,
    output o_gnt,
    output o_gnt_idx,
    output o_gnt_valid,
    output o_timeout
  );
endinterface

// File: rtl/rr_decode_arbiter.sv
// Round-robin arbiter for 8 requesters driving a one-hot 3:8 select bus.
// Grants are held until release, owner withdrawal or a MAX_HOLD-cycle tenure limit.
module rr_decode_arbiter #(
  parameter int unsigned MAX_HOLD = 16
) (
  input logic                clk,
  input logic                rst,
  rr_decode_arbiter_if.slave bus
);

  localparam int unsigned N     = 8;
  localparam int unsigned IDX_W = 3;
  localparam int unsigned CNT_W = $clog2(MAX_HOLD) + 1;

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e             r_state, w_state_d;
  logic [IDX_W-1:0]   r_ptr, w_ptr_d;
  logic [CNT_W-1:0]   r_hold_cnt, w_hold_cnt_d;
  logic [IDX_W-1:0]   r_gnt_idx, w_gnt_idx_d;
  logic [N-1:0]       r_gnt, w_gnt_d;
  logic               r_gnt_valid, w_gnt_valid_d;
  logic               r_timeout, w_timeout_d;

  logic [IDX_W-1:0]   w_win_idx;
  logic               w_win_found;
  logic               w_rel, w_wd, w_max;

  // First requester at or after r_ptr, wrapping 7 -> 0.
  always_comb begin
    logic [IDX_W-1:0] cand;
    w_win_idx   = r_ptr;
    w_win_found = 1'b0;
    cand        = r_ptr;
    for (int k = 0; k < int'(N); k++) begin
      cand = r_ptr + IDX_W'(k);
      if (!w_win_found && bus.i_req[cand]) begin
        w_win_idx   = cand;
        w_win_found = 1'b1;
      end
    end
  end

  assign w_rel = bus.i_release;
  assign w_wd  = ~bus.i_req[r_gnt_idx];
  assign w_max = (r_hold_cnt == CNT_W'(MAX_HOLD - 1));

  always_comb begin
    w_state_d     = r_state;
    w_ptr_d       = r_ptr;
    w_hold_cnt_d  = r_hold_cnt;
    w_gnt_idx_d   = r_gnt_idx;
    w_gnt_d       = r_gnt;
    w_gnt_valid_d = r_gnt_valid;
    w_timeout_d   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_win_found) begin
          w_gnt_idx_d   = w_win_idx;
          w_gnt_d       = N'(1) << w_win_idx;
          w_gnt_valid_d = 1'b1;
          w_hold_cnt_d  = '0;
          w_state_d     = StGrant;
        end
      end
      StGrant: begin
        w_hold_cnt_d = r_hold_cnt + 1'b1;
        if (w_rel || w_wd || w_max) begin
          w_gnt_d       = '0;
          w_gnt_valid_d = 1'b0;
          w_hold_cnt_d  = '0;
          w_ptr_d       = r_gnt_idx + 1'b1;
          // Timeout only flags tenures ended purely by the hold limit.
          w_timeout_d   = w_max && !w_rel && !w_wd;
          w_state_d     = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_ptr       <= '0;
      r_hold_cnt  <= '0;
      r_gnt_idx   <= '0;
      r_gnt       <= '0;
      r_gnt_valid <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_ptr       <= w_ptr_d;
      r_hold_cnt  <= w_hold_cnt_d;
      r_gnt_idx   <= w_gnt_idx_d;
      r_gnt       <= w_gnt_d;
      r_gnt_valid <= w_gnt_valid_d;
      r_timeout   <= w_timeout_d;
    end
  end

  assign bus.o_gnt       = r_gnt;
  assign bus.o_gnt_idx   = r_gnt_idx;
  assign bus.o_gnt_valid = r_gnt_valid;
  assign bus.o_timeout   = r_timeout;

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Bench for rr_decode_arbiter: behavioural model feeds a scoreboard queue checked each
// cycle, plus directed checks of rotation, timeout, withdrawal and async reset.
module tb_rr_decode_arbiter;

  localparam int MAX_HOLD = 16;

  typedef struct packed {
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       valid;
    logic       tmo;
  } exp_t;

  logic clk;
  logic rst;
  int   n_total;
  int   n_bad;
  exp_t sb_q[$];

  rr_decode_arbiter_if bus ();

  rr_decode_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: owner is -1 when idle, ten counts cycles already granted.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_ten   = 0;

  always @(posedge clk) begin
    exp_t e;
    logic to;
    to = 1'b0;
    if (rst) begin
      m_owner = -1;
      m_ptr   = 0;
      m_ten   = 0;
    end else if (m_owner < 0) begin
      if (bus.i_req != 8'h00) begin
        for (int k = 0; k < 8; k++) begin
          if (m_owner < 0 && bus.i_req[(m_ptr + k) % 8]) m_owner = (m_ptr + k) % 8;
        end
        m_ten = 1;
      end
    end else begin
      if (bus.i_release || !bus.i_req[m_owner] || m_ten == MAX_HOLD) begin
        to      = (m_ten == MAX_HOLD) && !bus.i_release && bus.i_req[m_owner];
        m_ptr   = (m_owner + 1) % 8;
        m_owner = -1;
        m_ten   = 0;
      end else begin
        m_ten++;
      end
    end
    e.valid = (m_owner >= 0);
    e.gnt   = (m_owner >= 0) ? (8'h01 << m_owner) : 8'h00;
    e.idx   = (m_owner >= 0) ? 3'(m_owner) : 3'd0;
    e.tmo   = to;
    sb_q.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("sb_gnt", 32'(bus.o_gnt), 32'(e.gnt));
      chk("sb_valid", 32'(bus.o_gnt_valid), 32'(e.valid));
      chk("sb_timeout", 32'(bus.o_timeout), 32'(e.tmo));
      if (e.valid) chk("sb_idx", 32'(bus.o_gnt_idx), 32'(e.idx));
    end
  end

  task automatic wait_valid();
    int n;
    n = 0;
    while (!bus.o_gnt_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("wait_grant", 32'(bus.o_gnt_valid), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int cnt;
    int tcnt;
    n_total = 0;
    n_bad   = 0;
    rst           = 1'b1;
    bus.i_req     = 8'h00;
    bus.i_release = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_gnt", 32'(bus.o_gnt), 32'h00);
    chk("rst_idx", 32'(bus.o_gnt_idx), 32'd0);
    chk("rst_valid", 32'(bus.o_gnt_valid), 32'd0);
    chk("rst_timeout", 32'(bus.o_timeout), 32'd0);
    rst = 1'b0;

    // 1: single requester, release 3 cycles after grant.
    @(negedge clk);
    bus.i_req = 8'h04;
    @(negedge clk);
    chk("t1_gnt", 32'(bus.o_gnt), 32'h04);
    chk("t1_idx", 32'(bus.o_gnt_idx), 32'd2);
    repeat (2) @(negedge clk);
    bus.i_release = 1'b1;
    bus.i_req     = 8'h00;
    @(negedge clk);
    bus.i_release = 1'b0;
    chk("t1_gnt_off", 32'(bus.o_gnt), 32'h00);

    // 2: all requesting, strict rotation from index 0 with wrap.
    do_reset();
    bus.i_req = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      wait_valid();
      chk("t2_idx", 32'(bus.o_gnt_idx), 32'(i % 8));
      @(negedge clk);
      bus.i_release = 1'b1;
      @(negedge clk);
      bus.i_release = 1'b0;
      chk("t2_gap", 32'(bus.o_gnt_valid), 32'd0);
    end

    // 3: owner 5 never releases; tenure capped at MAX_HOLD.
    bus.i_req = 8'h20;
    wait_valid();
    cnt  = 0;
    tcnt = 0;
    while (bus.o_gnt_valid && cnt < 40) begin
      cnt++;
      tcnt += int'(bus.o_timeout);
      @(negedge clk);
    end
    tcnt += int'(bus.o_timeout);
    chk("t3_tenure", 32'(cnt), 32'(MAX_HOLD));
    @(negedge clk);
    tcnt += int'(bus.o_timeout);
    chk("t3_regrant_idx", 32'(bus.o_gnt_idx), 32'd5);
    chk("t3_tmo_pulses", 32'(tcnt), 32'd1);

    // 4: owner 3 withdraws while 6 waits.
    bus.i_req = 8'h00;
    @(negedge clk);
    bus.i_req = 8'h08;
    wait_valid();
    chk("t4_idx3", 32'(bus.o_gnt_idx), 32'd3);
    bus.i_req = 8'h48;
    @(negedge clk);
    bus.i_req = 8'h40;
    @(negedge clk);
    chk("t4_gap", 32'(bus.o_gnt), 32'h00);
    @(negedge clk);
    chk("t4_gnt6", 32'(bus.o_gnt), 32'h40);

    // 5: release coincides with the final hold cycle.
    repeat (MAX_HOLD - 1) @(negedge clk);
    chk("t5_still_held", 32'(bus.o_gnt_valid), 32'd1);
    bus.i_release = 1'b1;
    @(negedge clk);
    bus.i_release = 1'b0;
    chk("t5_end", 32'(bus.o_gnt_valid), 32'd0);
    chk("t5_no_tmo", 32'(bus.o_timeout), 32'd0);

    // 6: async reset mid-grant with owner 5.
    bus.i_req = 8'h20;
    repeat (2) @(negedge clk);
    wait_valid();
    chk("t6_idx5", 32'(bus.o_gnt_idx), 32'd5);
    bus.i_req = 8'hFF;
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("t6_async_gnt", 32'(bus.o_gnt), 32'h00);
    chk("t6_async_valid", 32'(bus.o_gnt_valid), 32'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    wait_valid();
    chk("t6_first_idx", 32'(bus.o_gnt_idx), 32'd0);

    bus.i_req = 8'h00;
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
